updown_counter: RTL and testbench
=================================

Name: updown_counter

Overview:
Parametrised up/down counter that generalises the basic enable-only counter. It adds a programmable modulus, direction control, synchronous clear, parallel load, and a choice between wrap and saturate at the limits. It provides terminal-count flags and a registered wrap pulse so it can be chained. It is intended for timing generators, divide-by-N dividers and address sequencers in the iCE40 designs.

Parameters:
WIDTH, 8, counter width in bits.
MAX, 2**WIDTH-1, inclusive top count. Must satisfy 1 <= MAX <= 2**WIDTH-1; this is checked by an elaboration-time assertion.
SATURATE, 0, selects limit behaviour. 0 = wrap at the limits; 1 = hold at the limits.

Ports:
clk  input  1  system clock; all logic is on the rising edge.
reset  input  1  synchronous, active-low reset.
enable  input  1  count enable.
dir  input  1  count direction. 1 = up, 0 = down.
clear  input  1  synchronous clear to 0.
load  input  1  parallel load strobe.
load_val  input  WIDTH  value to load.
val  output  WIDTH  current count (registered).
at_max  output  1  combinational, val == MAX.
at_zero  output  1  combinational, val == 0.
wrap  output  1  registered one-cycle pulse on a limit wrap.

Behaviour:
- Interface (already decided): one clock; reset is synchronous and active-low.
- Reset values: while reset is 0 at a rising clk edge, val <= 0 and wrap <= 0. Consequently at_zero = 1 and at_max = 0.
- Priority per rising edge, highest first: reset low, then clear, then load, then enable, otherwise hold.
- clear: val <= 0, wrap <= 0. It overrides a simultaneous load or enable.
- load: val <= min(load_val, MAX), wrap <= 0. Out-of-range load values clamp to MAX. load overrides enable in the same cycle.
- enable=1, dir=1:
  - val < MAX: val <= val+1.
  - val == MAX, SATURATE=0: val <= 0 and wrap <= 1.
  - val == MAX, SATURATE=1: val holds at MAX and wrap <= 0.
- enable=1, dir=0:
  - val > 0: val <= val-1.
  - val == 0, SATURATE=0: val <= MAX and wrap <= 1.
  - val == 0, SATURATE=1: val holds at 0 and wrap <= 0.
- enable=0: val holds.
- wrap:
  - Asserts in the same cycle the wrapped value appears on val (one cycle after the causing edge).
  - Lasts exactly one cycle unless another wrap occurs on the next edge. With MAX=1 and continuous enable, wrap stays high every other cycle.
- Latency: any control input sampled at edge N is reflected on val immediately after edge N. There is no pipeline.
- Arithmetic: next-value computation is WIDTH bits wide. No carry beyond WIDTH is ever produced because MAX <= 2**WIDTH-1. The comparisons against MAX use a WIDTH-bit constant.
- Direction changes take effect on the next enabled edge with no dead cycle.
- Reset asserted mid-count forces val to 0 on that edge, regardless of enable, load or clear.
- Inputs while reset is low are ignored.
- No X propagation: all outputs are defined from the first reset edge onward.

Test Plan:
- WIDTH=8, MAX=9, SATURATE=0: hold reset low for 1 edge, then enable=1, dir=1 for 10 edges. Required: val steps 1..9 then 0. wrap is high only in the cycle val==0 after 9. at_max is high only when val==9.
- WIDTH=8, MAX=9, SATURATE=0, down-count: start at 0, dir=0, enable=1 for 1 edge. Required: val==9 and wrap==1. On the next edge val==8 and wrap==0.
- WIDTH=8, MAX=9, SATURATE=1: count up from 0 for 12 edges. Required: val reaches 9 and holds at 9, and wrap stays 0 throughout. Then dir=0 for 12 edges: val reaches 0 and holds, and at_zero==1.
- Load:
  - load=1, load_val=8'h05, enable=1 for 1 edge: val==5, not 6.
  - load_val=8'hC8 with MAX=9: val==9 (clamped).
- Priority:
  - clear=1, load=1, load_val=7, enable=1: val==0.
  - Next cycle, hold reset low with clear=0 and load=1: val==0.
  - Release reset, enable with dir=1 for 2 edges: val==2.
- Enable toggle: count to 3, enable=0 for 2 edges (val stays 3), then enable=1 for 1 edge: val==4. Flip dir=0 for 1 edge: val==3 with no dead cycle.

Source files
------------

// File: rtl/updown_counter.sv
// Up/down modulo-(MAX+1) counter with clear, clamped load, wrap/saturate limits and a registered wrap pulse.
// Zero latency: controls sampled at an edge show on val right after it; no backpressure, counts whenever enabled.
module updown_counter #(
  parameter int WIDTH    = 8,
  parameter int MAX      = 2**WIDTH - 1,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             dir,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] val,
  output logic             at_max,
  output logic             at_zero,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
  localparam bit               SAT   = (SATURATE != 0);

  if (MAX < 1 || longint'(MAX) > ((longint'(1) << WIDTH) - 1)) begin : g_bad_max
    $error("updown_counter: MAX must lie in 1..2**WIDTH-1");
  end

  logic [WIDTH-1:0] load_clamped;

  assign at_max       = (val == MAX_V);
  assign at_zero      = (val == '0);
  assign load_clamped = (load_val > MAX_V) ? MAX_V : load_val;

  always_ff @(posedge clk) begin
    if (!reset) begin
      val  <= '0;
      wrap <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (clear) begin
        val <= '0;
      end else if (load) begin
        val <= load_clamped;
      end else if (enable) begin
        if (dir) begin
          if (!at_max) begin
            val <= val + ONE;
          end else if (!SAT) begin
            val  <= '0;
            wrap <= 1'b1;
          end
        end else begin
          // Saturating mode simply leaves val unchanged at either limit.
          if (!at_zero) begin
            val <= val - ONE;
          end else if (!SAT) begin
            val  <= MAX_V;
            wrap <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_updown_counter.sv
// Scoreboard bench: three counter configurations share one stimulus stream and are checked against an arithmetic model.
module tb_updown_counter;

  typedef struct packed {
    logic [7:0] val;
    logic       wrap;
    logic       at_max;
    logic       at_zero;
  } obs_t;

  typedef struct packed {
    obs_t o0;
    obs_t o1;
    obs_t o2;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset, enable, dir, clear, load;
  logic [7:0] load_val;

  logic [7:0] val0, val1, val2;
  logic       at_max0, at_max1, at_max2;
  logic       at_zero0, at_zero1, at_zero2;
  logic       wrap0, wrap1, wrap2;

  int total = 0;
  int bad   = 0;
  exp_t exp_q[$];

  // Model state per configuration: index 0 wraps at 9, 1 saturates at 9, 2 wraps at 1.
  int mx[3]    = '{9, 9, 1};
  int sat[3]   = '{0, 1, 0};
  int m_val[3] = '{0, 0, 0};
  bit m_wrap[3] = '{0, 0, 0};

  always #5 clk = ~clk;

  updown_counter #(.WIDTH(8), .MAX(9), .SATURATE(0)) u_wrap9 (
    .clk(clk), .reset(reset), .enable(enable), .dir(dir), .clear(clear),
    .load(load), .load_val(load_val), .val(val0), .at_max(at_max0),
    .at_zero(at_zero0), .wrap(wrap0)
  );

  updown_counter #(.WIDTH(8), .MAX(9), .SATURATE(1)) u_sat9 (
    .clk(clk), .reset(reset), .enable(enable), .dir(dir), .clear(clear),
    .load(load), .load_val(load_val), .val(val1), .at_max(at_max1),
    .at_zero(at_zero1), .wrap(wrap1)
  );

  updown_counter #(.WIDTH(8), .MAX(1), .SATURATE(0)) u_wrap1 (
    .clk(clk), .reset(reset), .enable(enable), .dir(dir), .clear(clear),
    .load(load), .load_val(load_val), .val(val2), .at_max(at_max2),
    .at_zero(at_zero2), .wrap(wrap2)
  );

  function automatic obs_t mk_obs(int i);
    obs_t o;
    o.val     = 8'(m_val[i]);
    o.wrap    = m_wrap[i];
    o.at_max  = (m_val[i] == mx[i]);
    o.at_zero = (m_val[i] == 0);
    return o;
  endfunction

  // Reference behaviour: integer counting with modulo (MAX+1) wrap or clamping.
  task automatic model_edge(input bit r, input bit en, input bit d, input bit clr,
                            input bit ld, input int lv);
    for (int i = 0; i < 3; i++) begin
      int n;
      m_wrap[i] = 1'b0;
      if (!r || clr) begin
        m_val[i] = 0;
      end else if (ld) begin
        m_val[i] = (lv > mx[i]) ? mx[i] : lv;
      end else if (en) begin
        n = m_val[i] + (d ? 1 : -1);
        if (n < 0 || n > mx[i]) begin
          if (sat[i] == 0) begin
            n = (n + mx[i] + 1) % (mx[i] + 1);
            m_wrap[i] = 1'b1;
          end else begin
            n = m_val[i];
          end
        end
        m_val[i] = n;
      end
    end
  endtask

  task automatic step(input bit r, input bit en, input bit d, input bit clr,
                      input bit ld, input int lv);
    exp_t e;
    @(negedge clk);
    reset    = r;
    enable   = en;
    dir      = d;
    clear    = clr;
    load     = ld;
    load_val = 8'(lv);
    model_edge(r, en, d, clr, ld, lv);
    e.o0 = mk_obs(0);
    e.o1 = mk_obs(1);
    e.o2 = mk_obs(2);
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input obs_t act, input obs_t req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s t=%0t: got val=%0d wrap=%b max=%b zero=%b, expected val=%0d wrap=%b max=%b zero=%b",
               name, $time, act.val, act.wrap, act.at_max, act.at_zero,
               req.val, req.wrap, req.at_max, req.at_zero);
    end
  endtask

  // Monitor: every edge produces a fresh output sample, matched to the oldest expectation.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check("wrap9", {val0, wrap0, at_max0, at_zero0}, e.o0);
        check("sat9",  {val1, wrap1, at_max1, at_zero1}, e.o1);
        check("wrap1", {val2, wrap2, at_max2, at_zero2}, e.o2);
      end
    end
  end

  initial begin
    reset = 1'b0; enable = 1'b0; dir = 1'b1; clear = 1'b0; load = 1'b0; load_val = '0;

    // Reset, then count up through the top of the range.
    step(0, 0, 1, 0, 0, 0);
    repeat (10) step(1, 1, 1, 0, 0, 0);
    // Down from zero wraps to MAX, then continues down.
    step(1, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    // Saturation sweep: up 12, down 12.
    step(1, 0, 1, 1, 0, 0);
    repeat (12) step(1, 1, 1, 0, 0, 0);
    repeat (12) step(1, 1, 0, 0, 0, 0);
    // Load beats enable; out-of-range load clamps.
    step(1, 1, 1, 0, 1, 8'h05);
    step(1, 0, 1, 0, 1, 8'hC8);
    // Priority: clear over load/enable, reset over load, then resume.
    step(1, 1, 1, 1, 1, 7);
    step(0, 0, 1, 0, 1, 7);
    repeat (2) step(1, 1, 1, 0, 0, 0);
    // Enable toggle and direction flip without a dead cycle.
    step(1, 0, 1, 1, 0, 0);
    repeat (3) step(1, 1, 1, 0, 0, 0);
    repeat (2) step(1, 0, 1, 0, 0, 0);
    step(1, 1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);

    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      step($urandom_range(99, 0) >= 2,
           $urandom_range(99, 0) < 75,
           $urandom_range(1, 0) == 1,
           $urandom_range(99, 0) < 4,
           $urandom_range(99, 0) < 8,
           int'($urandom_range(255, 0)));
    end

    begin
      int budget = 20;
      while (exp_q.size() > 0 && budget > 0) begin
        @(posedge clk);
        budget--;
      end
      #2;
      if (exp_q.size() > 0) begin
        total++;
        bad++;
        $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
